// File: rtl/instr_mem.sv
// Instruction memory: 2048 x 16 words. Reads are combinational at program_counter.
// Writes are synchronous at the same address. An asynchronous reset clears every word to NOP.
module instr_mem #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_write,
  input  logic [ADDR_WIDTH-1:0] program_counter,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // The whole array must clear without a clock, so it lives in flops rather than block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_write) begin
      mem_q[program_counter] <= data_in;
    end
  end

  assign rd_word  = mem_q[program_counter];
  // The gate holds the output at NOP for the whole reset window, including the instant rst_n falls.
  assign data_out = rst_n ? rd_word : '0;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem. It runs the directed plan and then a random
// read/write mix, checked against an array model of the memory.
module tb_instr_mem;
  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_write = 1'b0;
  logic [AW-1:0] program_counter = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;

  logic [DW-1:0] model [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  instr_mem dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_write        (en_write),
    .program_counter (program_counter),
    .data_in         (data_in),
    .data_out        (data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic rd(input string tag, input int addr);
    program_counter = AW'(addr);
    #1;
    check_eq(tag, data_out, model[addr]);
  endtask

  // One write cycle. Inputs change on the falling edge, and the model updates after the rising edge.
  task automatic wr(input int addr, input logic [DW-1:0] d);
    @(negedge clk);
    program_counter = AW'(addr);
    data_in  = d;
    en_write = 1'b1;
    @(posedge clk);
    #1;
    if (rst_n) model[addr] = d;
    @(negedge clk);
    en_write = 1'b0;
  endtask

  initial begin
    int addr;
    logic [DW-1:0] d;

    model_clear();
    // Attempt a write while reset is held. It must be ignored.
    program_counter = AW'(3);
    data_in  = 16'hBEEF;
    en_write = 1'b1;
    @(negedge clk);
    #1 check_eq("out_in_reset", data_out, 16'h0000);
    @(negedge clk);
    en_write = 1'b0;
    rst_n = 1'b1;

    rd("rst_pc0", 0);
    rd("rst_pc10", 10);
    rd("rst_pc100", 100);
    rd("rst_pc2047", 2047);
    rd("rst_pc3_nowrite", 3);

    wr(0, 16'h1234);
    rd("wr_pc0", 0);
    wr(0, 16'h5678);
    rd("overwrite_pc0", 0);
    rd("pc10_untouched", 10);
    wr(10, 16'hABCD);
    wr(100, 16'hFFFF);
    rd("pc10_abcd", 10);
    rd("pc100_ffff", 100);
    rd("pc0_5678", 0);
    wr(2047, 16'h0F0F);
    rd("pc2047_0f0f", 2047);

    // With the write enable low, several clock edges must not change memory.
    @(negedge clk);
    data_in = 16'hDEAD;
    program_counter = AW'(10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rd("we0_hold", 10);

    // Read during a write to the same address: the old value shows before the edge and the new value after it.
    wr(5, 16'h1111);
    @(negedge clk);
    program_counter = AW'(5);
    data_in  = 16'h2222;
    en_write = 1'b1;
    #1 check_eq("rdw_before", data_out, 16'h1111);
    @(posedge clk);
    #1 check_eq("rdw_after", data_out, 16'h2222);
    model[5] = 16'h2222;
    @(negedge clk);
    en_write = 1'b0;

    // Change the address between edges. The output must follow without a clock.
    program_counter = AW'(100);
    #1 check_eq("comb_addr", data_out, 16'hFFFF);

    // Assert reset mid-cycle, away from any clock edge.
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_drop", data_out, 16'h0000);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    rd("post_rst_pc0", 0);
    rd("post_rst_pc5", 5);
    rd("post_rst_pc10", 10);
    rd("post_rst_pc100", 100);
    rd("post_rst_pc2047", 2047);

    // Random mix. Addresses favour a small hot set so that overwrites actually happen.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(3) == 0) addr = $urandom_range(7);
      else if ($urandom_range(7) == 0) addr = ($urandom_range(1) == 0) ? 0 : DEPTH - 1;
      else addr = $urandom_range(DEPTH - 1);
      d = DW'($urandom);
      case ($urandom_range(2))
        0: wr(addr, d);
        1: rd("rand_rd", addr);
        default: begin
          // Toggle data_in across an edge while the write enable stays low.
          @(negedge clk);
          program_counter = AW'(addr);
          data_in = d;
          @(posedge clk);
          @(negedge clk);
          rd("rand_idle", addr);
        end
      endcase
    end
    for (int k = 0; k < 8; k++) rd("hot_final", k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
